ooo_decode_stage: RTL
=====================

# ooo_decode_stage

Registered, WIDTH-wide decode stage for the out-of-order pipeline. Each cycle it accepts a bundle of WIDTH instruction words from fetch and decodes every slot's opcode into dispatch control bits and register fields. It presents the decoded bundle to dispatch through a valid/ready handshake with a one-entry skid buffer. It also squashes non-dispatching slots, tracks HALT, flags illegal opcodes and honours pipeline flush.

## Interface
- WIDTH, 2: instruction slots per bundle (1..4); slot 0 is oldest.
- BYTE_OPS, 0: 1 = opcodes 0x14–0x17 decode as ADDB/ADDBI/SUBB/SUBBI; 0 = they decode as BEQ/BGT/BGE/BLE.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all held bundles and leave HALTED.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32*WIDTH  slot i = bits [32i+31:32i]; opcode [31:26], rd [25:21], rs [20:16], rt [15:11].
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  dispatch consumes.
- out_slot_valid, out_writeRd, out_RegDest, out_mem_wen, out_mem_ren, out_read_rs, out_read_rt  out  WIDTH each  per-slot control.
- out_rd, out_rs, out_rt  out  5*WIDTH each  per-slot register fields.
- halted  out  1  HALT has been accepted and stage is frozen.
- illegal  out  1  sticky: an undefined opcode was accepted.

## Operation
Decode groups, hex opcodes. Each group lists its asserted controls; all others are 0.
- writeRd, RegDest, rs, rt: ADD 01, SUB 03, AND 09, OR 0C, XOR 0E; with BYTE_OPS=1, also 14 and 16.
- writeRd, RegDest, rs: SLL 06, SRA 07, SRL 08.
- RegDest, rs: ADDI 02, MOV 05, ANDI 0A, NOT 0B, ORI 0D, XORI 0F, JALR 1C; with BYTE_OPS=1, also 15 and 17.
- LW 11: RegDest, rs, mem_ren.
- RegDest only: LUI 04, JAL 1B, LDCC 22, LDIC 23.
- rs, rt: B 13, BLT 18, BNE 19; with BYTE_OPS=0, also 14–17.
- SW 12: rs, rt, mem_wen.
- rs only: JR 1D.
- No controls, but slot valid: J 1A, STRCNT 20, STPCNT 21, HALT 31.
- Non-dispatching (slot_valid=0, all controls 0): NOP 00, TX 30.
- Undefined: any other opcode is non-dispatching and sets illegal.

Slot and bundle rules:
- out_slot_valid[i] = 1 only for dispatching opcodes.
- Register fields pass through unchanged, even for squashed slots.
- HALT in slot k squashes slots k+1..WIDTH-1 of the same bundle.
- A bundle with all slots squashed is still presented (out_valid=1, no live slots).

State machine: RUN → HALTED when a bundle containing HALT is accepted.
- HALTED: in_ready=0 and halted=1. Already-held bundles still drain to dispatch.
- HALTED → RUN only on flush or rst.

Flush:
- In the flush cycle, in_ready=0 and no bundle is accepted.
- Next edge: output register and skid buffer invalidated, state = RUN, illegal cleared.
- Flush wins over every simultaneous event.

## Timing
Reset values: out_valid=0, all out_* = 0, halted=0, illegal=0, state RUN, skid empty. in_ready=1 one cycle after rst deasserts.

Latency and throughput:
- Accept (in_valid && in_ready) at edge N makes the decoded bundle visible at out_valid after edge N.
- Throughput is one bundle per cycle while out_ready=1.

Handshake rules:
- While out_valid=1 and out_ready=0, out_* hold stable.
- If a bundle is accepted while the output stalls, it goes to the skid entry.
- When the output register is consumed, the skid bundle moves to the output on that same edge.

in_ready = !skid_full && state==RUN && !flush. It is registered from skid occupancy, so there is no combinational path from out_ready.

Boundary cases:
- Skid full and out_ready=1 in the same cycle: in_ready stays 0 that cycle; it rises the next cycle.
- HALT accepted at edge N: in_ready=0 from cycle N+1; halted=1 after edge N.
- rst mid-stall: outputs clear immediately (asynchronous); the held bundle is lost.

## Test plan
- Back-to-back accept, out_ready=1: slot0 ADD (0x04000000|rd=3,rs=1,rt=2) and slot1 LW → next cycle, slot0 writeRd=RegDest=read_rs=read_rt=1, out_rd=3; slot1 mem_ren=1, RegDest=1, read_rt=0.
- Stall: hold out_ready=0 and send 2 bundles → first bundle held stable, second in skid, in_ready=0; raise out_ready → both delivered in order on consecutive cycles, with no loss or duplication.
- HALT in slot0 with ADD in slot1 → slot_valid=01b, halted=1, in_ready=0 indefinitely; flush → in_ready=1 on the next cycle, halted=0.
- BYTE_OPS=0 vs 1, opcode 0x14 → BEQ controls (rs, rt, no RegDest) vs ADDB controls (writeRd, RegDest, rs, rt).
- NOP, TX, and opcode 0x3F → slot_valid=0; only 0x3F sets illegal=1; illegal stays set across bundles until flush.
- Assert rst asynchronously while out_valid=1 and skid full → out_valid=0 immediately; after release, in_ready=1 and illegal=0.

Source files
------------

// File: rtl/ooo_decode_stage.sv
// ooo_decode_stage: WIDTH-slot registered decode with a one-entry skid buffer.
// Decodes opcodes into dispatch controls, tracks HALT, sticky illegal, and flush.
module ooo_decode_stage #(
   parameter int WIDTH    = 2,
   parameter bit BYTE_OPS = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [32*WIDTH-1:0]  in_instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_slot_valid,
   output logic [WIDTH-1:0]     out_writeRd,
   output logic [WIDTH-1:0]     out_RegDest,
   output logic [WIDTH-1:0]     out_mem_wen,
   output logic [WIDTH-1:0]     out_mem_ren,
   output logic [WIDTH-1:0]     out_read_rs,
   output logic [WIDTH-1:0]     out_read_rt,
   output logic [5*WIDTH-1:0]   out_rd,
   output logic [5*WIDTH-1:0]   out_rs,
   output logic [5*WIDTH-1:0]   out_rt,
   output logic                 halted,
   output logic                 illegal
);

   typedef struct packed {
      logic       sv;
      logic       wr;
      logic       rdst;
      logic       mw;
      logic       mr;
      logic       urs;
      logic       urt;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
   } slot_t;

   typedef enum logic {RUN, HALTED} state_t;

   // Returns {undefined, sv, wr, rdst, mw, mr, rs, rt} for one opcode.
   function automatic logic [7:0] decode_op(input logic [5:0] op);
      logic [7:0] r;
      r = 8'b0;
      unique case (op)
         6'h01, 6'h03, 6'h09, 6'h0C, 6'h0E:
            r = 8'b0111_0011;
         6'h06, 6'h07, 6'h08:
            r = 8'b0111_0010;
         6'h02, 6'h05, 6'h0A, 6'h0B, 6'h0D, 6'h0F, 6'h1C:
            r = 8'b0101_0010;
         6'h11:
            r = 8'b0101_0110;
         6'h04, 6'h1B, 6'h22, 6'h23:
            r = 8'b0101_0000;
         6'h13, 6'h18, 6'h19:
            r = 8'b0100_0011;
         6'h12:
            r = 8'b0100_1011;
         6'h1D:
            r = 8'b0100_0010;
         6'h1A, 6'h20, 6'h21, 6'h31:
            r = 8'b0100_0000;
         6'h14, 6'h16:
            r = BYTE_OPS ? 8'b0111_0011 : 8'b0100_0011;
         6'h15, 6'h17:
            r = BYTE_OPS ? 8'b0101_0010 : 8'b0100_0011;
         6'h00, 6'h30:
            r = 8'b0000_0000;
         default:
            r = 8'b1000_0000;
      endcase
      return r;
   endfunction

   state_t               state_q, state_d;
   logic                 out_vld_q, out_vld_d;
   logic                 skid_vld_q, skid_vld_d;
   logic                 illegal_q, illegal_d;
   slot_t [WIDTH-1:0]    out_q, out_d;
   slot_t [WIDTH-1:0]    skid_q, skid_d;
   slot_t [WIDTH-1:0]    dec_b;
   logic                 dec_halt;
   logic                 dec_undef;
   logic                 accept;

   // Decode every slot; slots younger than a HALT are squashed.
   always_comb begin
      logic [5:0] op;
      logic [7:0] c;
      dec_b     = '0;
      dec_halt  = 1'b0;
      dec_undef = 1'b0;
      op        = '0;
      c         = '0;
      for (int i = 0; i < WIDTH; i++) begin
         op = in_instr[32*i+26 +: 6];
         c  = decode_op(op);
         dec_b[i].rd = in_instr[32*i+21 +: 5];
         dec_b[i].rs = in_instr[32*i+16 +: 5];
         dec_b[i].rt = in_instr[32*i+11 +: 5];
         if (!dec_halt) begin
            {dec_b[i].sv, dec_b[i].wr, dec_b[i].rdst, dec_b[i].mw,
             dec_b[i].mr, dec_b[i].urs, dec_b[i].urt} = c[6:0];
         end
         dec_undef = dec_undef | c[7];
         if (op == 6'h31) dec_halt = 1'b1;
      end
   end

   // Handshake, skid steering, HALT tracking and flush.
   always_comb begin
      in_ready   = !skid_vld_q && (state_q == RUN) && !flush;
      accept     = in_valid && in_ready;
      state_d    = state_q;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      illegal_d  = illegal_q;
      out_d      = out_q;
      skid_d     = skid_q;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
         state_d    = RUN;
         illegal_d  = 1'b0;
      end else begin
         if (accept && dec_halt)  state_d   = HALTED;
         if (accept && dec_undef) illegal_d = 1'b1;
         if (!out_vld_q || out_ready) begin
            if (skid_vld_q) begin
               out_d      = skid_q;
               out_vld_d  = 1'b1;
               skid_vld_d = 1'b0;
            end else if (accept) begin
               out_d     = dec_b;
               out_vld_d = 1'b1;
            end else begin
               out_vld_d = 1'b0;
            end
         end else if (accept) begin
            skid_d     = dec_b;
            skid_vld_d = 1'b1;
         end
      end
   end

   // State, output and skid registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         illegal_q  <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         illegal_q  <= illegal_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
      end
   end

   // Unpack the output register onto the per-slot ports.
   always_comb begin
      out_valid = out_vld_q;
      halted    = (state_q == HALTED);
      illegal   = illegal_q;
      out_slot_valid = '0;
      out_writeRd    = '0;
      out_RegDest    = '0;
      out_mem_wen    = '0;
      out_mem_ren    = '0;
      out_read_rs    = '0;
      out_read_rt    = '0;
      out_rd         = '0;
      out_rs         = '0;
      out_rt         = '0;
      for (int i = 0; i < WIDTH; i++) begin
         out_slot_valid[i] = out_q[i].sv;
         out_writeRd[i]    = out_q[i].wr;
         out_RegDest[i]    = out_q[i].rdst;
         out_mem_wen[i]    = out_q[i].mw;
         out_mem_ren[i]    = out_q[i].mr;
         out_read_rs[i]    = out_q[i].urs;
         out_read_rt[i]    = out_q[i].urt;
         out_rd[5*i +: 5]  = out_q[i].rd;
         out_rs[5*i +: 5]  = out_q[i].rs;
         out_rt[5*i +: 5]  = out_q[i].rt;
      end
   end

endmodule
